spi_ram_ctrl: RTL and testbench
===============================

// Module: spi_ram_ctrl
// PURPOSE
//   Command decoder + single-port RAM directly downstream of the SPI slave.
//   Consumes 10-bit frames (rx_data/rx_valid): bits[9:8] opcode, bits[7:0] payload.
//   Executes address/data writes and reads. Returns read bytes to the SPI slave on
//   dout/tx_valid for serial shift-out on MISO.
// PARAMETERS
//   MEM_DEPTH  256  number of 8-bit words
//   ADDR_SIZE  8    address width; MEM_DEPTH <= 2**ADDR_SIZE
//   AUTO_INC   1    1: address register post-increments after each data access
// PORTS
//   clk       in   1   single clock, rising edge
//   rst_n     in   1   asynchronous, active-low reset
//   din       in   10  frame from SPI slave rx_data
//   rx_valid  in   1   one-cycle strobe; each high cycle = one frame
//   dout      out  8   read data to SPI slave tx_data
//   tx_valid  out  1   dout valid; held until next accepted frame
//   cmd_err   out  1   one-cycle pulse: frame rejected
// BEHAVIOUR
//   Reset (async assert, sync release): dout=0, tx_valid=0, cmd_err=0, wr_addr=0,
//     rd_addr=0, wr_armed=0, rd_armed=0, state=IDLE. RAM contents not reset.
//   Opcodes, decoded on rx_valid=1 in IDLE or RD_HOLD:
//     00 WR_ADDR: payload<MEM_DEPTH -> wr_addr<=payload, wr_armed<=1; else cmd_err.
//     01 WR_DATA: wr_armed -> mem[wr_addr]<=payload same edge; AUTO_INC -> wr_addr+1;
//                 else cmd_err, RAM unchanged.
//     10 RD_ADDR: payload<MEM_DEPTH -> rd_addr<=payload, rd_armed<=1; else cmd_err.
//     11 RD_DATA: rd_armed -> issue RAM read, go RD_FETCH; else cmd_err.
//                 Payload ignored.
//   FSM: IDLE, RD_FETCH, RD_HOLD.
//     IDLE -> RD_FETCH on accepted RD_DATA.
//     RD_FETCH (1 cycle): dout<=mem[rd_addr], tx_valid<=1, AUTO_INC -> rd_addr+1,
//       -> RD_HOLD. tx_valid rises 2 edges after the RD_DATA strobe.
//     RD_HOLD: dout/tx_valid stable. Any rx_valid: tx_valid<=0 same edge, frame
//       decoded as in IDLE (RD_DATA -> RD_FETCH, others -> IDLE).
//   rx_valid during RD_FETCH: frame dropped, cmd_err=1; fetch completes normally.
//   Address increment wraps MEM_DEPTH-1 -> 0, also for non-power-of-2 depth.
//   Arming persists across frames. Cleared only by reset or a rejected *_ADDR frame.
//   cmd_err is registered and asserts the edge after the offending strobe.
//   Reset mid-read: tx_valid drops immediately (async), pending fetch is discarded.
// STRUCTURE
//   Shared package spi_pkg: opcode constants OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01,
//     OP_RD_ADDR=2'b10, OP_RD_DATA=2'b11; FSM state encoding.
//     Also used by spi_slave for its MOSI command-bit decode.
//   Sub-module spi_ram_array: parameterised single-port sync RAM (we, addr, wdata,
//     rdata, 1-cycle read latency). No reset. Infers block RAM.
//   Top holds the FSM, address/arm registers and output registers.
// TESTING
//   1 WR_ADDR 0x10, WR_DATA 0xA5, RD_ADDR 0x10, RD_DATA -> tx_valid 2 edges later,
//     dout=0xA5, held until next strobe.
//   2 AUTO_INC=1: WR_ADDR 0xFF, WR_DATA 0x11, WR_DATA 0x22; then reading addr 0xFF,0x00
//     -> 0x11, 0x22 (wrap).
//   3 After reset: WR_DATA 0x55 -> cmd_err pulse, RAM unchanged; RD_DATA -> cmd_err,
//     tx_valid stays 0.
//   4 MEM_DEPTH=200: RD_ADDR 0xC8 -> cmd_err, rd_armed stays 0; RD_ADDR 0xC7 accepted,
//     auto-inc wraps to 0.
//   5 rx_valid strobes on consecutive cycles RD_DATA, WR_ADDR -> second dropped with
//     cmd_err; dout valid.
//   6 rst_n low while in RD_FETCH -> tx_valid=0, dout=0 immediately, state IDLE,
//     arms cleared.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI command definitions: frame opcodes and the RAM controller FSM encoding.
package spi_pkg;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_RD_FETCH = 2'b01,
    S_RD_HOLD  = 2'b10
  } state_t;

endpackage

// File: rtl/spi_ram_ctrl_if.sv
// Frame/read-data bundle between the SPI slave (master side) and the RAM controller.
interface spi_ram_ctrl_if;
  logic [9:0] din;
  logic       rx_valid;
  logic [7:0] dout;
  logic       tx_valid;
  logic       cmd_err;

  modport master (output din, rx_valid, input dout, tx_valid, cmd_err);
  modport slave  (input din, rx_valid, output dout, tx_valid, cmd_err);
endinterface

// File: rtl/spi_ram_array.sv
// Single-port synchronous RAM, one-cycle read latency, no reset.
module spi_ram_array #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Write on we; registered read on re.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/spi_ram_ctrl.sv
// Command decoder for SPI frames driving a single-port RAM; returns read bytes.
module spi_ram_ctrl
  import spi_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter int AUTO_INC  = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  spi_ram_ctrl_if.slave  bus
);

  state_t                 state, state_nxt;
  logic [ADDR_SIZE-1:0]   wr_addr, wr_addr_nxt, rd_addr, rd_addr_nxt, ram_addr;
  logic                   wr_armed, wr_armed_nxt, rd_armed, rd_armed_nxt;
  logic [7:0]             dout_q, dout_nxt, ram_rdata;
  logic                   tx_valid_q, tx_valid_nxt, cmd_err_q, cmd_err_nxt;
  logic                   ram_we, ram_re;
  logic [1:0]             opcode;
  logic [7:0]             payload;
  logic                   addr_ok;

  assign opcode  = bus.din[9:8];
  assign payload = bus.din[7:0];
  assign addr_ok = int'(payload) < MEM_DEPTH;

  function automatic logic [ADDR_SIZE-1:0] addr_inc(input logic [ADDR_SIZE-1:0] a);
    return (int'(a) == MEM_DEPTH - 1) ? '0 : a + ADDR_SIZE'(1);
  endfunction

  spi_ram_array #(.DEPTH(MEM_DEPTH), .AW(ADDR_SIZE), .DW(8)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (payload),
    .rdata (ram_rdata)
  );

  // Next-state decode. RD_HOLD decodes frames exactly like IDLE, but any strobe drops tx_valid.
  always_comb begin
    state_nxt    = state;
    wr_addr_nxt  = wr_addr;
    rd_addr_nxt  = rd_addr;
    wr_armed_nxt = wr_armed;
    rd_armed_nxt = rd_armed;
    dout_nxt     = dout_q;
    tx_valid_nxt = tx_valid_q;
    cmd_err_nxt  = 1'b0;
    ram_we       = 1'b0;
    ram_re       = 1'b0;
    ram_addr     = rd_addr;
    case (state)
      S_RD_FETCH: begin
        dout_nxt     = ram_rdata;
        tx_valid_nxt = 1'b1;
        state_nxt    = S_RD_HOLD;
        if (AUTO_INC != 0) rd_addr_nxt = addr_inc(rd_addr);
        if (bus.rx_valid) cmd_err_nxt = 1'b1;
      end
      default: begin
        if (bus.rx_valid) begin
          tx_valid_nxt = 1'b0;
          state_nxt    = S_IDLE;
          case (opcode)
            OP_WR_ADDR: begin
              if (addr_ok) begin
                wr_addr_nxt  = ADDR_SIZE'(payload);
                wr_armed_nxt = 1'b1;
              end else begin
                wr_armed_nxt = 1'b0;
                cmd_err_nxt  = 1'b1;
              end
            end
            OP_WR_DATA: begin
              if (wr_armed) begin
                ram_we   = 1'b1;
                ram_addr = wr_addr;
                if (AUTO_INC != 0) wr_addr_nxt = addr_inc(wr_addr);
              end else begin
                cmd_err_nxt = 1'b1;
              end
            end
            OP_RD_ADDR: begin
              if (addr_ok) begin
                rd_addr_nxt  = ADDR_SIZE'(payload);
                rd_armed_nxt = 1'b1;
              end else begin
                rd_armed_nxt = 1'b0;
                cmd_err_nxt  = 1'b1;
              end
            end
            OP_RD_DATA: begin
              if (rd_armed) begin
                ram_re    = 1'b1;
                state_nxt = S_RD_FETCH;
              end else begin
                cmd_err_nxt = 1'b1;
              end
            end
            default: cmd_err_nxt = 1'b1;
          endcase
        end
      end
    endcase
  end

  // State, address/arm and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      wr_addr    <= '0;
      rd_addr    <= '0;
      wr_armed   <= 1'b0;
      rd_armed   <= 1'b0;
      dout_q     <= '0;
      tx_valid_q <= 1'b0;
      cmd_err_q  <= 1'b0;
    end else begin
      state      <= state_nxt;
      wr_addr    <= wr_addr_nxt;
      rd_addr    <= rd_addr_nxt;
      wr_armed   <= wr_armed_nxt;
      rd_armed   <= rd_armed_nxt;
      dout_q     <= dout_nxt;
      tx_valid_q <= tx_valid_nxt;
      cmd_err_q  <= cmd_err_nxt;
    end
  end

  assign bus.dout     = dout_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.cmd_err  = cmd_err_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed bench for spi_ram_ctrl: 256-deep instance plus a 200-deep instance for wrap/range.
module tb_spi_ram_ctrl;
  import spi_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  spi_ram_ctrl_if ifa ();
  spi_ram_ctrl_if ifb ();

  spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(ifa)
  );
  spi_ram_ctrl #(.MEM_DEPTH(200), .ADDR_SIZE(8), .AUTO_INC(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(ifb)
  );

  always #5 clk = ~clk;

  // One-cycle strobe on instance b (1) or a (0); returns at the negedge after the sampling edge.
  task automatic send(input bit b, input logic [1:0] op, input logic [7:0] pl);
    @(negedge clk);
    if (b) begin ifb.din = {op, pl}; ifb.rx_valid = 1'b1; end
    else   begin ifa.din = {op, pl}; ifa.rx_valid = 1'b1; end
    @(negedge clk);
    ifa.rx_valid = 1'b0;
    ifb.rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (ifa.dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h want 00", ifa.dout); end
    checks++; if (ifa.tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b want 0", ifa.tx_valid); end
    checks++; if (ifa.cmd_err !== 1'b0) begin errors++; $display("FAIL reset_cmd_err: got %b want 0", ifa.cmd_err); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    send(0, OP_WR_ADDR, 8'h10);
    checks++; if (ifa.cmd_err !== 1'b0) begin errors++; $display("FAIL wr_addr_err: got %b want 0", ifa.cmd_err); end
    send(0, OP_WR_DATA, 8'hA5);
    checks++; if (ifa.cmd_err !== 1'b0) begin errors++; $display("FAIL wr_data_err: got %b want 0", ifa.cmd_err); end
    send(0, OP_RD_ADDR, 8'h10);
    send(0, OP_RD_DATA, 8'h00);
    checks++; if (ifa.tx_valid !== 1'b0) begin errors++; $display("FAIL rd_latency_1: got %b want 0", ifa.tx_valid); end
    @(negedge clk);
    checks++; if (ifa.tx_valid !== 1'b1) begin errors++; $display("FAIL rd_latency_2: got %b want 1", ifa.tx_valid); end
    checks++; if (ifa.dout !== 8'hA5) begin errors++; $display("FAIL rd_data: got %h want a5", ifa.dout); end
    repeat (3) @(negedge clk);
    checks++; if (ifa.tx_valid !== 1'b1 || ifa.dout !== 8'hA5) begin errors++; $display("FAIL rd_hold: got %b/%h want 1/a5", ifa.tx_valid, ifa.dout); end
    send(0, OP_WR_ADDR, 8'h00);
    checks++; if (ifa.tx_valid !== 1'b0) begin errors++; $display("FAIL hold_release: got %b want 0", ifa.tx_valid); end
  endtask

  task automatic test_auto_inc_wrap();
    send(0, OP_WR_ADDR, 8'hFF);
    send(0, OP_WR_DATA, 8'h11);
    send(0, OP_WR_DATA, 8'h22);
    send(0, OP_RD_ADDR, 8'hFF);
    send(0, OP_RD_DATA, 8'h00);
    @(negedge clk);
    checks++; if (ifa.tx_valid !== 1'b1 || ifa.dout !== 8'h11) begin errors++; $display("FAIL wrap_rd_ff: got %b/%h want 1/11", ifa.tx_valid, ifa.dout); end
    send(0, OP_RD_DATA, 8'h00);
    checks++; if (ifa.tx_valid !== 1'b0) begin errors++; $display("FAIL wrap_hold_drop: got %b want 0", ifa.tx_valid); end
    @(negedge clk);
    checks++; if (ifa.tx_valid !== 1'b1 || ifa.dout !== 8'h22) begin errors++; $display("FAIL wrap_rd_00: got %b/%h want 1/22", ifa.tx_valid, ifa.dout); end
  endtask

  task automatic test_unarmed();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    send(0, OP_WR_DATA, 8'h55);
    checks++; if (ifa.cmd_err !== 1'b1) begin errors++; $display("FAIL unarmed_wr_err: got %b want 1", ifa.cmd_err); end
    @(negedge clk);
    checks++; if (ifa.cmd_err !== 1'b0) begin errors++; $display("FAIL cmd_err_pulse: got %b want 0", ifa.cmd_err); end
    send(0, OP_RD_DATA, 8'h00);
    checks++; if (ifa.cmd_err !== 1'b1) begin errors++; $display("FAIL unarmed_rd_err: got %b want 1", ifa.cmd_err); end
    @(negedge clk);
    checks++; if (ifa.tx_valid !== 1'b0) begin errors++; $display("FAIL unarmed_rd_tx: got %b want 0", ifa.tx_valid); end
    send(0, OP_RD_ADDR, 8'h00);
    send(0, OP_RD_DATA, 8'h00);
    @(negedge clk);
    checks++; if (ifa.tx_valid !== 1'b1 || ifa.dout !== 8'h22) begin errors++; $display("FAIL ram_unchanged: got %b/%h want 1/22", ifa.tx_valid, ifa.dout); end
  endtask

  task automatic test_depth200();
    send(1, OP_RD_ADDR, 8'hC8);
    checks++; if (ifb.cmd_err !== 1'b1) begin errors++; $display("FAIL d200_rd_addr_range: got %b want 1", ifb.cmd_err); end
    send(1, OP_RD_DATA, 8'h00);
    checks++; if (ifb.cmd_err !== 1'b1) begin errors++; $display("FAIL d200_not_armed: got %b want 1", ifb.cmd_err); end
    send(1, OP_WR_ADDR, 8'hC8);
    checks++; if (ifb.cmd_err !== 1'b1) begin errors++; $display("FAIL d200_wr_addr_range: got %b want 1", ifb.cmd_err); end
    send(1, OP_WR_ADDR, 8'hC7);
    send(1, OP_WR_DATA, 8'h3C);
    send(1, OP_WR_DATA, 8'h4D);
    send(1, OP_RD_ADDR, 8'hC7);
    checks++; if (ifb.cmd_err !== 1'b0) begin errors++; $display("FAIL d200_rd_addr_ok: got %b want 0", ifb.cmd_err); end
    send(1, OP_RD_DATA, 8'h00);
    @(negedge clk);
    checks++; if (ifb.tx_valid !== 1'b1 || ifb.dout !== 8'h3C) begin errors++; $display("FAIL d200_rd_c7: got %b/%h want 1/3c", ifb.tx_valid, ifb.dout); end
    send(1, OP_RD_DATA, 8'h00);
    @(negedge clk);
    checks++; if (ifb.tx_valid !== 1'b1 || ifb.dout !== 8'h4D) begin errors++; $display("FAIL d200_wrap: got %b/%h want 1/4d", ifb.tx_valid, ifb.dout); end
  endtask

  task automatic test_back_to_back();
    send(0, OP_RD_ADDR, 8'h10);
    @(negedge clk);
    ifa.din = {OP_RD_DATA, 8'h00}; ifa.rx_valid = 1'b1;
    @(negedge clk);
    ifa.din = {OP_WR_ADDR, 8'h05};
    @(negedge clk);
    ifa.rx_valid = 1'b0;
    checks++; if (ifa.cmd_err !== 1'b1) begin errors++; $display("FAIL b2b_cmd_err: got %b want 1", ifa.cmd_err); end
    checks++; if (ifa.tx_valid !== 1'b1 || ifa.dout !== 8'hA5) begin errors++; $display("FAIL b2b_dout: got %b/%h want 1/a5", ifa.tx_valid, ifa.dout); end
    @(negedge clk);
    checks++; if (ifa.cmd_err !== 1'b0 || ifa.tx_valid !== 1'b1) begin errors++; $display("FAIL b2b_after: got %b/%b want 0/1", ifa.cmd_err, ifa.tx_valid); end
  endtask

  task automatic test_reset_mid_read();
    send(0, OP_RD_ADDR, 8'h10);
    send(0, OP_RD_DATA, 8'h00);
    rst_n = 1'b0;
    #1;
    checks++; if (ifa.tx_valid !== 1'b0 || ifa.dout !== 8'h00) begin errors++; $display("FAIL mid_reset_async: got %b/%h want 0/00", ifa.tx_valid, ifa.dout); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (ifa.tx_valid !== 1'b0 || ifa.dout !== 8'h00) begin errors++; $display("FAIL mid_reset_discard: got %b/%h want 0/00", ifa.tx_valid, ifa.dout); end
    send(0, OP_RD_DATA, 8'h00);
    checks++; if (ifa.cmd_err !== 1'b1) begin errors++; $display("FAIL mid_reset_rd_disarm: got %b want 1", ifa.cmd_err); end
    send(0, OP_WR_DATA, 8'h77);
    checks++; if (ifa.cmd_err !== 1'b1) begin errors++; $display("FAIL mid_reset_wr_disarm: got %b want 1", ifa.cmd_err); end
  endtask

  initial begin
    ifa.din = '0; ifa.rx_valid = 1'b0;
    ifb.din = '0; ifb.rx_valid = 1'b0;
    test_reset();
    test_write_read();
    test_auto_inc_wrap();
    test_unarmed();
    test_depth200();
    test_back_to_back();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
